// File: rtl/pipe_scoreboard_if.sv
// Scoreboard issue/lookup bundle between the ID stage and pipe_scoreboard.
// master = ID-stage decode logic, slave = the scoreboard itself.
interface pipe_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_RD   = 2,
  parameter int LAT_W    = 2
);
  logic                     issue_valid;
  logic                     issue_we;
  logic [REG_AW-1:0]        issue_rd;
  logic [LAT_W-1:0]         issue_lat;
  logic [NUM_RD-1:0]        src_valid;
  logic [NUM_RD*REG_AW-1:0] src_addr;
  logic                     flush;
  logic                     stall;
  logic                     issue_fire;
  logic [NUM_RD*LAT_W-1:0]  fwd_dist;
  logic [NUM_REGS-1:0]      busy_vec;

  modport master (
    output issue_valid, issue_we, issue_rd, issue_lat, src_valid, src_addr, flush,
    input  stall, issue_fire, fwd_dist, busy_vec
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_lat, src_valid, src_addr, flush,
    output stall, issue_fire, fwd_dist, busy_vec
  );
endinterface

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: per-register write-back countdown for the in-order pipeline.
// Each architectural register holds the number of cycles until its pending
// write lands in the register file. Sources are looked up combinationally to
// produce the ID stall, a per-port bypass distance and a busy vector.
// Optional feature: define SCOREBOARD_FWD_EN to let sources whose countdown is
// within FWD_WIN proceed via the bypass network instead of stalling.
module pipe_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_RD   = 2,
  parameter int MAX_LAT  = 3,
  parameter int LAT_W    = 2,
  parameter int FWD_WIN  = 2
) (
  input  logic             clock,
  input  logic             reset,
  pipe_scoreboard_if.slave sb
);

  localparam logic [LAT_W:0]  MAX_LAT_W  = (LAT_W+1)'(MAX_LAT);
  localparam logic [REG_AW:0] NUM_REGS_W = (REG_AW+1)'(NUM_REGS);
`ifdef SCOREBOARD_FWD_EN
  localparam logic [LAT_W-1:0] FWD_LIM = LAT_W'(FWD_WIN);
`else
  // Without bypassing the window collapses to zero: any pending write stalls.
  localparam logic [LAT_W-1:0] FWD_LIM = LAT_W'(FWD_WIN * 0);
`endif

  logic [LAT_W-1:0]  cnt_reg  [NUM_REGS];
  logic [LAT_W-1:0]  cnt_next [NUM_REGS];
  logic [LAT_W-1:0]  lat_eff;
  logic              load;
  logic [NUM_RD-1:0] hazard;
  logic              stall_int;
  logic              fire_int;

  // Oversized latencies are clamped to the longest supported one.
  assign lat_eff = ({1'b0, sb.issue_lat} > MAX_LAT_W) ? MAX_LAT_W[LAT_W-1:0] : sb.issue_lat;

  // Only real register writes with a nonzero latency create an entry.
  assign load = fire_int & sb.issue_we & (sb.issue_rd != '0) & (sb.issue_lat != '0);

  // Per-register next count: decrement, then the WAW-safe max with a new issue.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      assign cnt_next[gi] = '0;
    end else begin : g_live
      logic [LAT_W-1:0] dec;
      assign dec = (cnt_reg[gi] != '0) ? cnt_reg[gi] - 1'b1 : '0;
      assign cnt_next[gi] = (load && (sb.issue_rd == REG_AW'(gi)) && (lat_eff > dec)) ? lat_eff : dec;
    end
    assign sb.busy_vec[gi] = (cnt_reg[gi] != '0);
  end

  // Counter bank; reset clears every pending write immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_reg[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_reg[r] <= cnt_next[r];
    end
  end

  // Per-port lookup against the current counts (older instructions only).
  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
    logic [REG_AW-1:0] addr;
    logic [LAT_W-1:0]  src_cnt;
    assign addr    = sb.src_addr[gi*REG_AW +: REG_AW];
    assign src_cnt = ({1'b0, addr} < NUM_REGS_W) ? cnt_reg[addr] : '0;
    assign hazard[gi] = sb.src_valid[gi] & (src_cnt != '0) & ~(src_cnt <= FWD_LIM);
`ifdef SCOREBOARD_FWD_EN
    assign sb.fwd_dist[gi*LAT_W +: LAT_W] = sb.src_valid[gi] ? src_cnt : '0;
`else
    assign sb.fwd_dist[gi*LAT_W +: LAT_W] = '0;
`endif
  end

  // Flush overrides stall; nothing issues or stalls while reset is held.
  assign stall_int     = reset & sb.issue_valid & ~sb.flush & (|hazard);
  assign fire_int      = reset & sb.issue_valid & ~sb.flush & ~stall_int;
  assign sb.stall      = stall_int;
  assign sb.issue_fire = fire_int;

endmodule
